// File: rtl/mips_rr_arb_mux.sv
// Registered N-channel stream selector: arbitrates valid/ready requesters by
// round-robin or fixed priority and forwards the winner through one output register.

module mips_rr_arb_lane #(
  parameter int CH_W    = 2,
  parameter int IDX     = 0,
  parameter bit RR_MODE = 1'b1
) (
  input  logic            valid_i,
  input  logic [CH_W-1:0] ptr_i,
  input  logic            grant_i,
  input  logic            load_i,
  input  logic            rst_n_i,
  output logic            req_hi_o,
  output logic            ready_o
);
  // A lane at or above the pointer belongs to the first search pass.
  assign req_hi_o = valid_i & (!RR_MODE || (IDX >= int'(ptr_i)));
  assign ready_o  = grant_i & load_i & rst_n_i;
endmodule

module mips_rr_arb_mux #(
  parameter int SIZE    = 32,
  parameter int NUM_CH  = 4,
  parameter int RR_MODE = 1,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic [NUM_CH*SIZE-1:0] InData,
  input  logic [NUM_CH-1:0]      InValid,
  output logic [NUM_CH-1:0]      InReady,
  output logic [SIZE-1:0]        OutData,
  output logic [CH_W-1:0]        OutChannel,
  output logic                   OutValid,
  input  logic                   OutReady
);
  logic [NUM_CH-1:0][SIZE-1:0] ch_data;
  logic [NUM_CH-1:0]           req_hi, grant;
  logic [CH_W-1:0]             ptr_q, gidx;
  logic [SIZE-1:0]             sel_data;
  logic                        found, load;
  logic [SIZE-1:0]             data_q;
  logic [CH_W-1:0]             ch_q;
  logic                        vld_q;

  assign ch_data = InData;
  assign load    = ~vld_q | OutReady;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    mips_rr_arb_lane #(.CH_W(CH_W), .IDX(i), .RR_MODE(RR_MODE != 0)) u_lane (
      .valid_i  (InValid[i]),
      .ptr_i    (ptr_q),
      .grant_i  (grant[i]),
      .load_i   (load),
      .rst_n_i  (Reset_n),
      .req_hi_o (req_hi[i]),
      .ready_o  (InReady[i])
    );
  end

  // Two-pass rotate: lowest request at/above Ptr, else lowest request overall.
  always_comb begin
    grant    = '0;
    gidx     = '0;
    sel_data = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req_hi[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gidx     = CH_W'(i);
        sel_data = ch_data[i];
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && InValid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gidx     = CH_W'(i);
        sel_data = ch_data[i];
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      data_q <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= '0;
    end else if (load) begin
      if (found) begin
        data_q <= sel_data;
        ch_q   <= gidx;
        vld_q  <= 1'b1;
        if (RR_MODE != 0)
          ptr_q <= (int'(gidx) == NUM_CH - 1) ? '0 : gidx + 1'b1;
      end else begin
        vld_q <= 1'b0;
      end
    end
  end

  assign OutData    = data_q;
  assign OutChannel = ch_q;
  assign OutValid   = vld_q;
endmodule

// File: tb/tb_mips_rr_arb_mux.sv
// Bench for mips_rr_arb_mux: RR and fixed-priority 4-channel builds plus a
// 1-channel build, each compared every cycle against a rule-level model.

module tb_mips_rr_arb_mux;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*W-1:0] ind [2];
  logic [N-1:0]   inv [2];
  logic [N-1:0]   inr [2];
  logic [W-1:0]   od  [2];
  logic [1:0]     oc  [2];
  logic           ov  [2];
  logic           ordy[2];

  logic [W-1:0] d1, od1;
  logic         v1, r1, ov1, or1;
  logic [0:0]   oc1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mips_rr_arb_mux #(.SIZE(W), .NUM_CH(N), .RR_MODE(1)) u_rr (
    .Clock(clk), .Reset_n(rst_n), .InData(ind[0]), .InValid(inv[0]), .InReady(inr[0]),
    .OutData(od[0]), .OutChannel(oc[0]), .OutValid(ov[0]), .OutReady(ordy[0]));

  mips_rr_arb_mux #(.SIZE(W), .NUM_CH(N), .RR_MODE(0)) u_fp (
    .Clock(clk), .Reset_n(rst_n), .InData(ind[1]), .InValid(inv[1]), .InReady(inr[1]),
    .OutData(od[1]), .OutChannel(oc[1]), .OutValid(ov[1]), .OutReady(ordy[1]));

  mips_rr_arb_mux #(.SIZE(W), .NUM_CH(1), .RR_MODE(1)) u_one (
    .Clock(clk), .Reset_n(rst_n), .InData(d1), .InValid(v1), .InReady(r1),
    .OutData(od1), .OutChannel(oc1), .OutValid(ov1), .OutReady(or1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Walk channels in priority order from the start point; -1 when nobody asks.
  function automatic int winner(input logic [N-1:0] v, input int ptr, input bit rr);
    for (int k = 0; k < N; k++) begin
      int c = rr ? (ptr + k) % N : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  logic        m_vld [2];
  logic [W-1:0] m_data[2];
  int          m_ch  [2];
  int          m_ptr [2];
  int          exp_g [2];
  logic        exp_ld[2];
  logic [N-1:0] exp_rdy[2];
  logic        m1_vld, exp_r1;
  logic [W-1:0] m1_data;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      exp_g[i]   = winner(inv[i], m_ptr[i], i == 0);
      exp_ld[i]  = !m_vld[i] || ordy[i];
      exp_rdy[i] = (rst_n && exp_ld[i] && exp_g[i] >= 0) ? (N'(1) << exp_g[i]) : '0;
    end
    exp_r1 = rst_n && v1 && (!m1_vld || or1);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_vld[i] <= 1'b0; m_data[i] <= '0; m_ch[i] <= 0; m_ptr[i] <= 0;
      end
      m1_vld <= 1'b0; m1_data <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (exp_ld[i]) begin
          if (exp_g[i] >= 0) begin
            m_vld[i]  <= 1'b1;
            m_data[i] <= ind[i][exp_g[i]*W +: W];
            m_ch[i]   <= exp_g[i];
            if (i == 0) m_ptr[i] <= (exp_g[i] + 1) % N;
          end else begin
            m_vld[i] <= 1'b0;
          end
        end
      end
      if (!m1_vld || or1) begin
        m1_vld <= v1;
        if (v1) m1_data <= d1;
      end
    end
  end

  logic [W-1:0] sent_q[$];
  int rcvd1 = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ov%0d", i), ov[i], m_vld[i]);
        chk($sformatf("inr%0d", i), inr[i], exp_rdy[i]);
        chk($sformatf("od%0d", i), od[i], m_data[i]);
        chk($sformatf("oc%0d", i), oc[i], m_ch[i]);
      end
      chk("ov1", ov1, m1_vld);
      chk("r1", r1, exp_r1);
      chk("oc1", oc1, 0);
      if (m1_vld) chk("od1", od1, m1_data);
      if (ov1 && or1) begin
        chk("one_q_nonempty", sent_q.size() > 0, 1);
        if (sent_q.size() > 0) chk("one_order", od1, sent_q.pop_front());
        rcvd1++;
      end
      if (v1 && r1) sent_q.push_back(d1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] words[5];
    logic [4:0]   pat;
    int           idx;
    bit           fire;
    for (int i = 0; i < 2; i++) begin
      ind[i] = '0; inv[i] = '0; ordy[i] = 1'b1;
    end
    d1 = '0; v1 = 1'b0; or1 = 1'b1;
    repeat (3) cyc();
    chk_en = 1'b1;
    chk("reset_ov", ov[0], 0);
    chk("reset_inr", inr[0], 0);
    rst_n = 1'b1;

    // Rotation on the RR build, priority hold on the fixed build.
    for (int c = 0; c < N; c++) begin
      ind[0][c*W +: W] = 32'hA000_0000 + c;
      ind[1][c*W +: W] = 32'hB000_0000 + c;
    end
    inv[0] = 4'b1111;
    inv[1] = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("rr_seq_ch", oc[0], k % 4);
      chk("rr_seq_data", od[0], 32'hA000_0000 + (k % 4));
      chk("rr_seq_vld", ov[0], 1);
      chk("fp_ch", oc[1], 1);
      chk("fp_rdy3", inr[1][3], 0);
    end
    inv[1] = 4'b1000;
    cyc();
    chk("fp_next_ch", oc[1], 3);
    chk("fp_next_data", od[1], 32'hB000_0003);

    // Backpressure while holding ch2.
    ind[0][2*W +: W] = 32'hDEAD_BEEF;
    inv[0] = 4'b0100;
    cyc();
    chk("bp_load_ch", oc[0], 2);
    ordy[0] = 1'b0;
    inv[0] = 4'b1111;
    repeat (3) begin
      cyc();
      chk("bp_hold_data", od[0], 32'hDEAD_BEEF);
      chk("bp_hold_rdy", inr[0], 0);
    end
    ordy[0] = 1'b1;
    #1;
    chk("bp_release_rdy", inr[0], 4'b1000);
    cyc();
    chk("bp_drain_ch", oc[0], 3);
    chk("bp_drain_data", od[0], 32'hA000_0003);

    // Pointer wrap and sparse requests.
    inv[0] = 4'b0100;
    cyc();
    inv[0] = 4'b0001;
    cyc();
    chk("wrap_ch", oc[0], 0);
    chk("wrap_data", od[0], 32'hA000_0000);
    inv[0] = 4'b0000;
    cyc();
    chk("idle_vld", ov[0], 0);
    inv[0] = 4'b0011;
    #1;
    chk("ptr_after_wrap", inr[0], 4'b0010);
    inv[0] = 4'b0000;
    cyc();

    // Single-channel stream under toggling OutReady.
    for (int i = 0; i < 5; i++) words[i] = 32'hC0DE_0000 + i;
    pat = 5'b01101;
    idx = 0;
    for (int c = 0; c < 40 && rcvd1 < 5; c++) begin
      v1  = idx < 5;
      d1  = (idx < 5) ? words[idx] : '0;
      or1 = pat[c % 5];
      #1;
      fire = v1 && r1;
      cyc();
      if (fire) idx++;
    end
    chk("one_count", rcvd1, 5);
    chk("one_leftover", sent_q.size(), 0);
    v1 = 1'b0; or1 = 1'b1;

    // Random traffic on both 4-channel builds.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        inv[i]  = N'($urandom);
        ind[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
        ordy[i] = $urandom_range(0, 3) != 0;
      end
      cyc();
    end

    // Asynchronous reset mid-cycle while holding a word.
    inv[0] = 4'b1111; ordy[0] = 1'b1;
    cyc();
    chk("pre_reset_vld", ov[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_vld", ov[0], 0);
    chk("async_data", od[0], 0);
    chk("async_ch", oc[0], 0);
    chk("async_rdy", inr[0], 0);
    inv[0] = '0; inv[1] = '0;
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("post_reset_vld", ov[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
